// File: rtl/receiver_control_unit_if.sv
// Receiver control unit bus: raw RX line in, sequencing flags and frame status out.
//   i_RX              raw serial line (idle high, asynchronous)
//   o_state_is_DATA   FSM in DATA
//   o_state_is_STOP   FSM in STOP
//   o_equal           end-of-bit-period strobe (DATA/STOP only)
//   o_busy            FSM not in IDLE
//   o_rx_done         one-cycle pulse, frame ended with a valid stop bit
//   o_framing_error   one-cycle pulse, stop bit sampled low
// master: the control unit; slave: the environment driving RX and observing status.
interface receiver_control_unit_if;
   logic i_RX;
   logic o_state_is_DATA;
   logic o_state_is_STOP;
   logic o_equal;
   logic o_busy;
   logic o_rx_done;
   logic o_framing_error;

   modport master (
      input  i_RX,
      output o_state_is_DATA,
      output o_state_is_STOP,
      output o_equal,
      output o_busy,
      output o_rx_done,
      output o_framing_error
   );

   modport slave (
      output i_RX,
      input  o_state_is_DATA,
      input  o_state_is_STOP,
      input  o_equal,
      input  o_busy,
      input  o_rx_done,
      input  o_framing_error
   );
endinterface

// File: rtl/receiver_control_unit.sv
// UART receive-path control unit. Synchronises RX, validates the start bit at mid-bit,
// times each data/stop bit and reports frame completion or framing error.
//   i_clock  system clock (rising edge)
//   i_reset  asynchronous active-high reset
//   bus      receiver_control_unit_if.master (RX in, state flags / strobes out)
module receiver_control_unit #(
   parameter int unsigned CLOCK_COUNTER_WIDTH = 10,
   parameter int unsigned BIT_COUNTER_WIDTH   = 3,
   parameter int unsigned DATA_WIDTH          = 8,
   parameter int unsigned CLOCKS_PER_BIT      = 434
) (
   input logic                     i_clock,
   input logic                     i_reset,
   receiver_control_unit_if.master bus
);

   localparam logic [CLOCK_COUNTER_WIDTH-1:0] CcLast =
      CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
   localparam logic [CLOCK_COUNTER_WIDTH-1:0] CcHalf =
      CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [BIT_COUNTER_WIDTH-1:0] BcLast =
      BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } state_e;

   state_e                         state_q, state_d;
   logic                           rx_meta_q, rx_s_q;
   logic [CLOCK_COUNTER_WIDTH-1:0] cc_q, cc_d;
   logic [BIT_COUNTER_WIDTH-1:0]   bc_q, bc_d;
   logic                           rx_done_q, rx_done_d;
   logic                           ferr_q, ferr_d;
   logic                           equal;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cc_q      <= '0;
         bc_q      <= '0;
         rx_done_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= bus.i_RX;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cc_q      <= cc_d;
         bc_q      <= bc_d;
         rx_done_q <= rx_done_d;
         ferr_q    <= ferr_d;
      end
   end

   // Only registered terms, so the strobe is glitch-free and zero in IDLE/START.
   assign equal = (cc_q == CcLast) && ((state_q == StData) || (state_q == StStop));

   always_comb begin
      state_d   = state_q;
      bc_d      = bc_q;
      rx_done_d = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            // Mid start bit: still low means a real start, high means a glitch.
            if (cc_q == CcHalf) state_d = rx_s_q ? StIdle : StData;
         end
         StData: begin
            if (equal) begin
               if (bc_q == BcLast) begin
                  bc_d    = '0;
                  state_d = StStop;
               end else begin
                  bc_d = bc_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (equal) begin
               state_d = StIdle;
               if (rx_s_q) rx_done_d = 1'b1;
               else        ferr_d    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Counter restarts on every state change so each state times from its own entry.
   always_comb begin
      cc_d = '0;
      if ((state_d == state_q) && (state_q != StIdle) && (cc_q != CcLast)) begin
         cc_d = cc_q + 1'b1;
      end
   end

   assign bus.o_state_is_DATA = (state_q == StData);
   assign bus.o_state_is_STOP = (state_q == StStop);
   assign bus.o_equal         = equal;
   assign bus.o_busy          = (state_q != StIdle);
   assign bus.o_rx_done       = rx_done_q;
   assign bus.o_framing_error = ferr_q;

endmodule

// File: tb/tb_receiver_control_unit.sv
module tb_receiver_control_unit;

   localparam int EvData = 0;
   localparam int EvStop = 1;
   localparam int EvEq   = 2;
   localparam int EvDone = 3;
   localparam int EvFerr = 4;

   typedef struct {
      int         unit;
      int         kind;
      int         cyc;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  sb_q[$];

   logic       prev_d [2] = '{1'b0, 1'b0};
   logic       prev_s [2] = '{1'b0, 1'b0};
   logic [7:0] shreg  [2] = '{8'h00, 8'h00};

   receiver_control_unit_if bus0 ();
   receiver_control_unit_if bus1 ();

   receiver_control_unit #(.CLOCKS_PER_BIT(16)) dut16 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus0)
   );

   receiver_control_unit dut434 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Compare one observed DUT event with the oldest expected one.
   task automatic observe(input int u, input int kind, input logic [7:0] data);
      ev_t e;
      checks++;
      assert (sb_q.size() > 0) else begin
         failures++;
         $error("FAIL unexpected_event unit=%0d kind=%0d cyc=%0d exp=none", u, kind, cyc);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         assert ((u === e.unit) && (kind === e.kind) && (cyc === e.cyc)) else begin
            failures++;
            $error("FAIL event got unit=%0d kind=%0d cyc=%0d exp unit=%0d kind=%0d cyc=%0d",
                   u, kind, cyc, e.unit, e.kind, e.cyc);
         end
         if (kind >= EvDone) begin
            checks++;
            assert (data === e.data) else begin
               failures++;
               $error("FAIL frame_data unit=%0d got=%0h exp=%0h", u, data, e.data);
            end
         end
      end
   endtask

   task automatic scan(input int u, input logic d, input logic s, input logic eq,
                       input logic done, input logic fe, input logic rx);
      if (d && !prev_d[u]) observe(u, EvData, 8'h00);
      if (s && !prev_s[u]) observe(u, EvStop, 8'h00);
      if (eq) begin
         // Shifter stand-in: sample the line mid-bit on each DATA strobe, LSB first.
         if (d) shreg[u] = {rx, shreg[u][7:1]};
         observe(u, EvEq, 8'h00);
      end
      if (done) observe(u, EvDone, shreg[u]);
      if (fe)   observe(u, EvFerr, shreg[u]);
      prev_d[u] = d;
      prev_s[u] = s;
   endtask

   always @(negedge clk) begin
      scan(0, bus0.o_state_is_DATA, bus0.o_state_is_STOP, bus0.o_equal,
           bus0.o_rx_done, bus0.o_framing_error, bus0.i_RX);
      scan(1, bus1.o_state_is_DATA, bus1.o_state_is_STOP, bus1.o_equal,
           bus1.o_rx_done, bus1.o_framing_error, bus1.i_RX);
   end

   task automatic push_ev(input int u, input int kind, input int c, input logic [7:0] data);
      ev_t e;
      e.unit = u;
      e.kind = kind;
      e.cyc  = c;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // Expected events of one frame whose START state is entered at edge t0.
   task automatic push_frame(input int u, input int t0, input int p, input logic [7:0] data,
                             input logic stop_ok);
      int h;
      h = p / 2;
      push_ev(u, EvData, t0 + h, 8'h00);
      for (int k = 0; k < 8; k++) push_ev(u, EvEq, t0 + h + p - 1 + k * p, 8'h00);
      push_ev(u, EvStop, t0 + h + 8 * p, 8'h00);
      push_ev(u, EvEq, t0 + h + 9 * p - 1, 8'h00);
      push_ev(u, stop_ok ? EvDone : EvFerr, t0 + h + 9 * p, data);
   endtask

   task automatic set_rx(input int u, input logic v);
      if (u == 0) bus0.i_RX = v;
      else        bus1.i_RX = v;
   endtask

   // Called just after a negedge; the low captured at the next edge reaches START two
   // edges later, hence t0 = cyc + 3.
   task automatic drive_frame(input int u, input logic [7:0] data, input logic stop_bit,
                              input int p, output int t0);
      t0 = cyc + 3;
      push_frame(u, t0, p, data, stop_bit);
      set_rx(u, 1'b0);
      repeat (p) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(u, data[i]);
         repeat (p) @(negedge clk);
      end
      set_rx(u, stop_bit);
      repeat (p) @(negedge clk);
   endtask

   task automatic goto(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   function automatic logic [5:0] flags0();
      return {bus0.o_busy, bus0.o_state_is_DATA, bus0.o_state_is_STOP, bus0.o_equal,
              bus0.o_rx_done, bus0.o_framing_error};
   endfunction

   function automatic logic [5:0] flags1();
      return {bus1.o_busy, bus1.o_state_is_DATA, bus1.o_state_is_STOP, bus1.o_equal,
              bus1.o_rx_done, bus1.o_framing_error};
   endfunction

   initial begin
      int t0;
      int c;

      rst       = 1'b1;
      bus0.i_RX = 1'b1;
      bus1.i_RX = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs_u0", 32'(flags0()), 32'h0);
      chk("reset_outputs_u1", 32'(flags1()), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_after_reset_u0", 32'(flags0()), 32'h0);
      chk("idle_after_reset_u1", 32'(flags1()), 32'h0);

      // Valid frame 0xA5: DATA at t0+8, strobes every 16, done at t0+152.
      drive_frame(0, 8'hA5, 1'b1, 16, t0);
      repeat (10) @(negedge clk);
      chk("idle_after_valid", 32'(flags0()), 32'h0);

      // Start glitch: 4 low cycles, rejected at mid start bit.
      c = cyc;
      t0 = c + 3;
      bus0.i_RX = 1'b0;
      repeat (4) @(negedge clk);
      bus0.i_RX = 1'b1;
      goto(t0 + 7);
      chk("glitch_in_start", 32'(flags0()), 32'h20);
      goto(t0 + 8);
      chk("glitch_rejected", 32'(flags0()), 32'h0);
      repeat (20) @(negedge clk);

      // Framing error 0x3C with low stop bit; line stays low so START re-enters.
      drive_frame(0, 8'h3C, 1'b0, 16, t0);
      chk("ferr_restart_start", 32'(flags0()), 32'h20);
      bus0.i_RX = 1'b1;
      goto(t0 + 161);
      chk("ferr_break_rejected", 32'(flags0()), 32'h0);
      repeat (20) @(negedge clk);

      // Back-to-back 0x00 then 0xFF, single stop bit between: done pulses 160 apart.
      drive_frame(0, 8'h00, 1'b1, 16, t0);
      drive_frame(0, 8'hFF, 1'b1, 16, t0);
      repeat (10) @(negedge clk);
      chk("idle_after_b2b", 32'(flags0()), 32'h0);

      // Reset during the 3rd data bit of 0x81.
      c  = cyc;
      t0 = c + 3;
      push_ev(0, EvData, t0 + 8, 8'h00);
      push_ev(0, EvEq, t0 + 23, 8'h00);
      push_ev(0, EvEq, t0 + 39, 8'h00);
      bus0.i_RX = 1'b0;
      repeat (16) @(negedge clk);
      bus0.i_RX = 1'b1;
      repeat (16) @(negedge clk);
      bus0.i_RX = 1'b0;
      repeat (16) @(negedge clk);
      repeat (7) @(negedge clk);
      chk("midframe_busy", 32'(flags0()), 32'h30);
      rst = 1'b1;
      #1;
      chk("midframe_reset_outputs", 32'(flags0()), 32'h0);
      repeat (3) @(negedge clk);
      rst       = 1'b0;
      bus0.i_RX = 1'b1;
      repeat (5) @(negedge clk);
      chk("after_reset_idle", 32'(flags0()), 32'h0);
      drive_frame(0, 8'h81, 1'b1, 16, t0);
      repeat (10) @(negedge clk);

      // Default parameters: 434 clocks/bit, done at t0+217+9*434.
      drive_frame(1, 8'h5A, 1'b1, 434, t0);
      repeat (10) @(negedge clk);
      chk("idle_after_default", 32'(flags1()), 32'h0);

      repeat (20) @(negedge clk);
      chk("all_events_seen", 32'(sb_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
